// File: rtl/approx_sweep_pkg.sv
// Shared types and accumulator widths for the approximate-adder sweep checker.
package approx_sweep_pkg;

    localparam int ERR_CNT_W = 18;
    localparam int SUM_ED_W  = 26;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DRAIN,
        DONE
    } sweep_state_e;

endpackage

// File: rtl/approx_err_dist.sv
// Unsigned error distance |(a+b+cin) - res| between the exact sum and an adder result.
module approx_err_dist #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [WIDTH:0]   res,
    output logic [WIDTH:0]   ed
);

    logic [WIDTH:0] exact;

    always_comb begin
        exact = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        ed    = (exact >= res) ? (exact - res) : (res - exact);
    end

endmodule

// File: rtl/approx_adder_sweep_checker.sv
// Sweeps every operand pair through an external adder and accumulates error statistics.
// Define SWEEP_CIN_EN to also sweep the carry-in (doubling the vector count).
module approx_adder_sweep_checker
    import approx_sweep_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [WIDTH-1:0]     op_a,
    output logic [WIDTH-1:0]     op_b,
    output logic                 op_cin,
    input  logic [WIDTH:0]       res_i,
    output logic                 busy,
    output logic                 done,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [WIDTH:0]       max_ed,
    output logic [SUM_ED_W-1:0]  sum_ed
);

    sweep_state_e          state_q, state_d;
    logic [WIDTH-1:0]      op_a_q, op_a_d, op_b_q, op_b_d;
    logic                  op_cin_q, op_cin_d;
    logic                  cap_valid_q, cap_valid_d;
    logic [WIDTH-1:0]      cap_a_q, cap_a_d, cap_b_q, cap_b_d;
    logic                  cap_cin_q, cap_cin_d;
    logic [WIDTH:0]        cap_res_q, cap_res_d;
    logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;
    logic [WIDTH:0]        max_ed_q, max_ed_d;
    logic [SUM_ED_W-1:0]   sum_ed_q, sum_ed_d;
    logic                  busy_q, busy_d, done_q, done_d;
    logic [WIDTH:0]        ed;
    logic                  last_vec;

    // Error distance is evaluated on the captured vector, one edge behind capture.
    approx_err_dist #(.WIDTH(WIDTH)) u_err_dist (
        .a   (cap_a_q),
        .b   (cap_b_q),
        .cin (cap_cin_q),
        .res (cap_res_q),
        .ed  (ed)
    );

`ifdef SWEEP_CIN_EN
    assign last_vec = (&op_a_q) & (&op_b_q) & op_cin_q;
`else
    assign last_vec = (&op_a_q) & (&op_b_q);
`endif

    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_cin_d    = op_cin_q;
        cap_valid_d = 1'b0;
        cap_a_d     = cap_a_q;
        cap_b_d     = cap_b_q;
        cap_cin_d   = cap_cin_q;
        cap_res_d   = cap_res_q;
        err_count_d = err_count_q;
        max_ed_d    = max_ed_q;
        sum_ed_d    = sum_ed_q;

        if (cap_valid_q) begin
            err_count_d = err_count_q + {{(ERR_CNT_W-1){1'b0}}, (ed != '0)};
            sum_ed_d    = sum_ed_q + SUM_ED_W'(ed);
            if (ed > max_ed_q) begin
                max_ed_d = ed;
            end
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = SWEEP;
                    op_a_d      = '0;
                    op_b_d      = '0;
                    op_cin_d    = 1'b0;
                    err_count_d = '0;
                    max_ed_d    = '0;
                    sum_ed_d    = '0;
                end
            end
            SWEEP: begin
                cap_valid_d = 1'b1;
                cap_a_d     = op_a_q;
                cap_b_d     = op_b_q;
                cap_cin_d   = op_cin_q;
                cap_res_d   = res_i;
                // op_b is the fastest-moving digit, then op_a, then carry-in.
                op_b_d = op_b_q + 1'b1;
                if (&op_b_q) begin
                    op_a_d = op_a_q + 1'b1;
                    if (&op_a_q) begin
`ifdef SWEEP_CIN_EN
                        op_cin_d = ~op_cin_q;
`else
                        op_cin_d = 1'b0;
`endif
                    end
                end
                if (last_vec) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == SWEEP) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_cin_q    <= 1'b0;
            cap_valid_q <= 1'b0;
            cap_a_q     <= '0;
            cap_b_q     <= '0;
            cap_cin_q   <= 1'b0;
            cap_res_q   <= '0;
            err_count_q <= '0;
            max_ed_q    <= '0;
            sum_ed_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_cin_q    <= op_cin_d;
            cap_valid_q <= cap_valid_d;
            cap_a_q     <= cap_a_d;
            cap_b_q     <= cap_b_d;
            cap_cin_q   <= cap_cin_d;
            cap_res_q   <= cap_res_d;
            err_count_q <= err_count_d;
            max_ed_q    <= max_ed_d;
            sum_ed_q    <= sum_ed_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign op_cin    = op_cin_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err_count = err_count_q;
    assign max_ed    = max_ed_q;
    assign sum_ed    = sum_ed_q;

endmodule

// File: tb/tb_approx_adder_sweep_checker.sv
// Self-checking bench: a behavioural adder model drives res_i, and the expected
// sweep statistics are queued at start and compared when done rises.
module tb_approx_adder_sweep_checker;

    localparam int W     = 4;
    localparam int RES_W = W + 1;
    localparam int MASK  = (1 << RES_W) - 1;
`ifdef SWEEP_CIN_EN
    localparam int NCIN = 2;
`else
    localparam int NCIN = 1;
`endif
    localparam int N = NCIN << (2 * W);

    typedef struct {
        int errCount;
        int maxEd;
        int sumEd;
    } expect_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [W-1:0]     op_a;
    logic [W-1:0]     op_b;
    logic             op_cin;
    logic [W:0]       res_i;
    logic             busy;
    logic             done;
    logic [17:0]      err_count;
    logic [W:0]       max_ed;
    logic [25:0]      sum_ed;

    int      mode;
    int      checkCount;
    int      errorCount;
    expect_t scoreboard[$];

    approx_adder_sweep_checker #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_cin    (op_cin),
        .res_i     (res_i),
        .busy      (busy),
        .done      (done),
        .err_count (err_count),
        .max_ed    (max_ed),
        .sum_ed    (sum_ed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder under test: 0 exact, 1 stuck at zero, 2 forces S[0]=1, 3 product-like garbage.
    function automatic int adderModel(input int m, input int a, input int b, input int cin);
        int exact;
        int r;
        exact = a + b + cin;
        case (m)
            0:       r = exact;
            1:       r = 0;
            2:       r = exact | 1;
            default: r = a * b + cin;
        endcase
        return r & MASK;
    endfunction

    assign res_i = RES_W'(adderModel(mode, int'(op_a), int'(op_b), int'(op_cin)));

    function automatic expect_t buildExpect(input int m);
        expect_t e;
        int ed;
        e.errCount = 0;
        e.maxEd    = 0;
        e.sumEd    = 0;
        for (int c = 0; c < NCIN; c++) begin
            for (int a = 0; a < (1 << W); a++) begin
                for (int b = 0; b < (1 << W); b++) begin
                    ed = a + b + c - adderModel(m, a, b, c);
                    if (ed < 0) ed = -ed;
                    if (ed != 0) e.errCount++;
                    if (ed > e.maxEd) e.maxEd = ed;
                    e.sumEd += ed;
                end
            end
        end
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int m);
        mode = m;
        scoreboard.push_back(buildExpect(m));
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " busy"}, busy, 0);
        checkOutput({tag, " done"}, done, 0);
        checkOutput({tag, " ops"}, {op_cin, op_a, op_b}, 0);
        checkOutput({tag, " err_count"}, err_count, 0);
        checkOutput({tag, " max_ed"}, max_ed, 0);
        checkOutput({tag, " sum_ed"}, sum_ed, 0);
    endtask

    // Runs one sweep; optionally pulses start or asserts reset at a given vector index.
    task automatic runSweep(input string name, input int m, input int pulseAt, input int resetAt);
        int      edges;
        bit      gotDone;
        expect_t e;
        edges   = 0;
        gotDone = 1'b0;
        applyStimulus(m);
        while (!gotDone && edges < 2 * N + 10) begin
            @(posedge clk);
            #1;
            edges++;
            start = 1'b0;
            if (edges < N) begin
                checkOutput({name, " ops"}, {op_cin, op_a, op_b}, edges);
            end
            if (edges <= N) begin
                checkOutput({name, " busy"}, busy, 1);
            end
            if (edges == pulseAt) begin
                start = 1'b1;
            end
            if (edges == resetAt) begin
                rst_n = 1'b0;
                #1;
                checkAllZero({name, " midreset"});
                void'(scoreboard.pop_front());
                @(negedge clk);
                rst_n = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                checkOutput({name, " idle busy"}, busy, 0);
                checkOutput({name, " idle done"}, done, 0);
                return;
            end
            if (done) gotDone = 1'b1;
        end
        checkOutput({name, " latency"}, edges, N + 1);
        e = scoreboard.pop_front();
        checkOutput({name, " err_count"}, err_count, e.errCount);
        checkOutput({name, " max_ed"}, max_ed, e.maxEd);
        checkOutput({name, " sum_ed"}, sum_ed, e.sumEd);
        repeat (5) @(posedge clk);
        #1;
        checkOutput({name, " hold done"}, done, 1);
        checkOutput({name, " hold busy"}, busy, 0);
        checkOutput({name, " hold sum_ed"}, sum_ed, e.sumEd);
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        mode       = 0;
        start      = 1'b0;
        rst_n      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("post-reset busy", busy, 0);
        checkOutput("post-reset done", done, 0);

        $display("[TB] sweeping %0d vectors per run", N);
        runSweep("exact", 0, -1, -1);
        runSweep("zero", 1, -1, -1);
        runSweep("lsb", 2, -1, -1);
        runSweep("prod", 3, -1, -1);
        runSweep("ignore", 0, 100, -1);
        runSweep("abort", 3, -1, 150);
        runSweep("after", 0, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/approx_adder_sweep_checker.md
APPROX_ADDER_SWEEP_CHECKER -- requirements
Module: approx_adder_sweep_checker

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width of the adder under test.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: single-cycle request to begin a sweep.
REQ-005 The block SHALL have ports op_a and op_b, outputs, WIDTH bits each: registered operands driven to the external adder.
REQ-006 The block SHALL have port op_cin, output, 1 bit: registered carry-in driven to the external adder.
REQ-007 The block SHALL have port res_i, input, WIDTH+1 bits: {Cout,S} from the external combinational adder.
REQ-008 The block SHALL have ports busy and done, outputs, 1 bit each: sweep in progress; results valid.
REQ-009 The block SHALL have port err_count, output, 18 bits: number of vectors with a nonzero error distance.
REQ-010 The block SHALL have port max_ed, output, WIDTH+1 bits: largest error distance seen.
REQ-011 The block SHALL have port sum_ed, output, 26 bits: sum of all error distances.

Function
REQ-012 The FSM SHALL have states IDLE, SWEEP, DRAIN and DONE; busy=1 exactly in SWEEP and DRAIN; done=1 exactly in DONE.
REQ-013 On the edge where start=1 in IDLE or DONE, the FSM SHALL enter SWEEP, zero op_a/op_b/op_cin, and zero all accumulators.
REQ-014 start during SWEEP or DRAIN SHALL be ignored.
REQ-015 Each SWEEP edge SHALL capture res_i together with the current operands into one pipeline register, then advance the operands: op_b innermost, then op_a, then op_cin.
REQ-016 On the edge capturing the last vector, the FSM SHALL go to DRAIN; the following edge SHALL accumulate that vector and go to DONE.
REQ-017 The exact reference SHALL be op_a+op_b+op_cin at WIDTH+1 bits; the error distance SHALL be |exact − res_i|, unsigned, WIDTH+1 bits.
REQ-018 Accumulation SHALL occur one edge after capture: err_count increments if ED≠0, max_ed=max(max_ed,ED), sum_ed+=ED.
REQ-019 Accumulators SHALL never wrap: widths cover the worst case of 2^(2·WIDTH+1) vectors at ED=2^(WIDTH+1)−1 when WIDTH=8.
REQ-020 done and all results SHALL hold in DONE until the next accepted start or reset.
REQ-021 Latency SHALL be exactly N+1 edges from the start-accepting edge to done=1, where N is the vector count.

Reset
REQ-022 On rst_n=0, at any time including mid-sweep, the block SHALL asynchronously enter IDLE and clear every output, register and accumulator to 0.
REQ-023 After release, the block SHALL stay in IDLE until start.

Configuration
REQ-024 With SWEEP_CIN_EN defined, op_cin SHALL sweep 0 then 1, giving N=2^(2·WIDTH+1).
REQ-025 Without SWEEP_CIN_EN, op_cin SHALL be held at 0 and N=2^(2·WIDTH); port list and widths are unchanged.

Structure
REQ-026 Package approx_sweep_pkg SHALL hold the FSM state typedef and the constants ERR_CNT_W=18 and SUM_ED_W=26.
REQ-027 The absolute-difference logic SHALL be a sub-module named approx_err_dist.

Verification
REQ-028 Exact adder connected, no macro: start at edge 0 -> done=1 after edge 65537; err_count=0, max_ed=0, sum_ed=0.
REQ-029 res_i tied to 0: err_count=65535, max_ed=510, sum_ed=16711680.
REQ-030 Adder that forces S[0]=1 over the exact sum: err_count=32768, max_ed=1, sum_ed=32768.
REQ-031 Pulse start at sweep vector 1000 -> ignored; final results are identical to REQ-028.
REQ-032 rst_n low at vector 30000 -> all outputs 0 and state IDLE immediately; a new start then gives results identical to REQ-028.
REQ-033 SWEEP_CIN_EN defined with the exact adder -> done after edge 131073, op_cin=1 from vector 65536, err_count=0.
